// File: rtl/ifetch_prefetch_unit_if.sv
// Handshake bundle between the fetch unit, the instruction memory port and decode.
// master is the fetch unit's view; slave is the memory/decode side.
interface ifetch_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_ir, if_npc,
    input  imem_ready, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_ir, if_npc,
    output imem_ready, imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/ifetch_prefetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, runs one outstanding memory request
// at a time and buffers {instruction, NPC} pairs in a small circular prefetch queue.
module ifetch_prefetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  ifetch_prefetch_unit_if.master   bus,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      ir_q  [DEPTH];
  logic [31:0]      npc_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic             push;
  logic             pop;
  logic             is_hlt;
  logic [PTR_W:0]   next_count;

  // A redirect suppresses both queue ports because the whole queue is flushed.
  assign push       = (state == S_WAIT) && bus.imem_rvalid && !branch_taken;
  assign pop        = (count != '0) && bus.id_ready && !branch_taken;
  assign is_hlt     = (bus.imem_rdata[31:26] == 6'b111111);
  assign next_count = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (branch_taken) begin
      fetch_pc <= branch_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // A request already accepted by memory must have its response swallowed in S_DROP.
      case (state)
        S_REQ:   state <= bus.imem_ready  ? S_DROP : S_REQ;
        S_WAIT:  state <= bus.imem_rvalid ? S_REQ  : S_DROP;
        S_DROP:  state <= bus.imem_rvalid ? S_REQ  : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      count <= next_count;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        ir_q[wr_ptr]  <= bus.imem_rdata;
        npc_q[wr_ptr] <= fetch_pc + 32'd1;
        wr_ptr        <= wr_ptr + 1'b1;
        fetch_pc      <= fetch_pc + 32'd1;
      end
      case (state)
        S_IDLE: if (count < FULL) state <= S_REQ;
        S_REQ:  if (bus.imem_ready) state <= S_WAIT;
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            if (is_hlt)                  state <= S_HALT;
            else if (next_count < FULL)  state <= S_REQ;
            else                         state <= S_IDLE;
          end
        end
        S_DROP: if (bus.imem_rvalid) state <= S_REQ;
        default: state <= state;
      endcase
    end
  end

  assign bus.imem_req  = (state == S_REQ);
  assign bus.imem_addr = fetch_pc;
  assign bus.if_valid  = (count != '0);
  assign bus.if_ir     = bus.if_valid ? ir_q[rd_ptr]  : 32'd0;
  assign bus.if_npc    = bus.if_valid ? npc_q[rd_ptr] : 32'd0;
  assign halted        = (state == S_HALT);
  assign occupancy     = count;

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Scoreboard bench for ifetch_prefetch_unit: a memory model with configurable latency,
// expected address and {ir, npc} queues, and a negedge monitor that checks deliveries.
module tb_ifetch_prefetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        halted;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  ifetch_prefetch_unit_if bus();

  ifetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halted(halted),
    .occupancy(occupancy)
  );

  logic [31:0] mem [64];
  int          lat = 1;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;
  int          hs_count = 0;
  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_q [$];
  int          checks = 0;
  int          fails = 0;

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory model: one outstanding request, response 'lat' cycles after the handshake edge.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(posedge clk);
      if (reset) begin
        pending = 1'b0;
      end else begin
        if (bus.imem_rvalid) pending = 1'b0;
        else if (pending)    cnt--;
        if (bus.imem_req && bus.imem_ready) begin
          logic [31:0] e;
          pending = 1'b1;
          cnt     = lat;
          paddr   = bus.imem_addr;
          hs_count++;
          if (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            check_output("imem_addr", bus.imem_addr, e);
          end
        end
      end
      #1;
      bus.imem_rvalid = pending && (cnt == 1);
      bus.imem_rdata  = bus.imem_rvalid ? mem[paddr[5:0]] : 32'hDEADBEEF;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.if_valid && bus.id_ready && !branch_taken && exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_output("if_ir", bus.if_ir, e[63:32]);
        check_output("if_npc", bus.if_npc, e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    tick(2);
    hs_count = 0;
  endtask

  task automatic expect_entry(logic [31:0] addr);
    logic [31:0] npc;
    npc = addr + 32'd1;
    exp_q.push_back({mem[addr[5:0]], npc});
  endtask

  task automatic apply_stimulus(logic [31:0] target);
    branch_taken  = 1'b1;
    branch_target = target;
    tick(1);
    branch_taken  = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      fails++;
      $display("[TB] FAIL %s: %0d entries never delivered, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_fetch(string name, logic [31:0] a, bit want_rvalid, int budget);
    int n = 0;
    while (!(pending && paddr == a && bus.imem_rvalid == want_rvalid) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("[TB] FAIL %s: timeout waiting for fetch of %h, required within %0d cycles", name, a, budget);
    end
  endtask

  task automatic wait_req(string name, logic [31:0] a, int budget);
    int n = 0;
    while (!(bus.imem_req && bus.imem_addr == a) && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("[TB] FAIL %s: timeout waiting for request of %h, required within %0d cycles", name, a, budget);
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    bus.imem_ready = 1'b1;
    bus.id_ready   = 1'b0;

    $display("[TB] test 1: streaming fetch");
    lat = 1;
    apply_reset();
    check_output("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check_output("rst_if_ir", bus.if_ir, 32'd0);
    check_output("rst_if_npc", bus.if_npc, 32'd0);
    check_output("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check_output("rst_halted", {31'd0, halted}, 32'd0);
    check_output("rst_occupancy", 32'(occupancy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      exp_addr_q.push_back(32'(k));
      expect_entry(32'(k));
    end
    bus.id_ready = 1'b1;
    reset = 1'b0;
    tick(1);
    check_output("first_req", {31'd0, bus.imem_req}, 32'd1);
    check_output("first_addr", bus.imem_addr, 32'd0);
    wait_drain("t1_drain", 200);

    $display("[TB] test 2: backpressure");
    apply_reset();
    bus.id_ready = 1'b0;
    for (int k = 0; k < 6; k++) exp_addr_q.push_back(32'(k));
    reset = 1'b0;
    tick(20);
    check_output("full_occupancy", 32'(occupancy), 32'd4);
    check_output("full_req", {31'd0, bus.imem_req}, 32'd0);
    check_output("full_hs_count", 32'(hs_count), 32'd4);
    for (int k = 0; k < 6; k++) expect_entry(32'(k));
    bus.id_ready = 1'b1;
    wait_drain("t2_drain", 200);

    $display("[TB] test 3: redirect while waiting");
    lat = 3;
    apply_reset();
    bus.id_ready = 1'b0;
    exp_addr_q.push_back(32'd0);
    exp_addr_q.push_back(32'd1);
    exp_addr_q.push_back(32'd2);
    exp_addr_q.push_back(32'd20);
    exp_addr_q.push_back(32'd21);
    reset = 1'b0;
    wait_fetch("t3_wait2", 32'd2, 1'b0, 100);
    check_output("t3_occ_before", 32'(occupancy), 32'd2);
    apply_stimulus(32'd20);
    check_output("t3_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check_output("t3_occ_after", 32'(occupancy), 32'd0);
    check_output("t3_req_drop", {31'd0, bus.imem_req}, 32'd0);
    expect_entry(32'd20);
    expect_entry(32'd21);
    bus.id_ready = 1'b1;
    wait_drain("t3_drain", 200);

    $display("[TB] test 4: HLT stop and restart");
    lat = 1;
    mem[5] = 32'hFC00_0000;
    apply_reset();
    bus.id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_addr_q.push_back(32'(k));
      expect_entry(32'(k));
    end
    reset = 1'b0;
    wait_drain("t4_drain", 200);
    tick(10);
    check_output("t4_halted", {31'd0, halted}, 32'd1);
    check_output("t4_req", {31'd0, bus.imem_req}, 32'd0);
    check_output("t4_hs_count", 32'(hs_count), 32'd6);
    for (int k = 0; k < 3; k++) begin
      exp_addr_q.push_back(32'(k));
      expect_entry(32'(k));
    end
    apply_stimulus(32'd0);
    check_output("t4_unhalted", {31'd0, halted}, 32'd0);
    check_output("t4_restart_req", {31'd0, bus.imem_req}, 32'd1);
    check_output("t4_restart_addr", bus.imem_addr, 32'd0);
    wait_drain("t4_restart_drain", 200);
    mem[5] = 32'h1000_0005;

    $display("[TB] test 5a: redirect with rvalid");
    lat = 2;
    apply_reset();
    bus.id_ready = 1'b0;
    exp_addr_q.push_back(32'd0);
    exp_addr_q.push_back(32'd1);
    exp_addr_q.push_back(32'd40);
    exp_addr_q.push_back(32'd41);
    reset = 1'b0;
    wait_fetch("t5a_wait1", 32'd1, 1'b1, 100);
    apply_stimulus(32'd40);
    check_output("t5a_req", {31'd0, bus.imem_req}, 32'd1);
    check_output("t5a_addr", bus.imem_addr, 32'd40);
    check_output("t5a_occ", 32'(occupancy), 32'd0);
    expect_entry(32'd40);
    bus.id_ready = 1'b1;
    wait_drain("t5a_drain", 200);

    $display("[TB] test 5b: redirect with ready");
    apply_reset();
    bus.id_ready = 1'b0;
    exp_addr_q.push_back(32'd0);
    exp_addr_q.push_back(32'd1);
    exp_addr_q.push_back(32'd2);
    exp_addr_q.push_back(32'd48);
    exp_addr_q.push_back(32'd49);
    reset = 1'b0;
    wait_req("t5b_req2", 32'd2, 100);
    apply_stimulus(32'd48);
    check_output("t5b_req_drop", {31'd0, bus.imem_req}, 32'd0);
    check_output("t5b_occ", 32'(occupancy), 32'd0);
    expect_entry(32'd48);
    expect_entry(32'd49);
    bus.id_ready = 1'b1;
    wait_drain("t5b_drain", 200);

    $display("[TB] test 6: reset mid-transaction");
    lat = 3;
    apply_reset();
    bus.id_ready = 1'b0;
    reset = 1'b0;
    wait_fetch("t6_wait2", 32'd2, 1'b0, 100);
    check_output("t6_occ_before", 32'(occupancy), 32'd2);
    reset = 1'b1;
    tick(1);
    check_output("t6_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check_output("t6_if_ir", bus.if_ir, 32'd0);
    check_output("t6_occ", 32'(occupancy), 32'd0);
    check_output("t6_req", {31'd0, bus.imem_req}, 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    exp_addr_q.push_back(32'd0);
    expect_entry(32'd0);
    reset = 1'b0;
    tick(1);
    check_output("t6_restart_req", {31'd0, bus.imem_req}, 32'd1);
    check_output("t6_restart_addr", bus.imem_addr, 32'd0);
    bus.id_ready = 1'b1;
    wait_drain("t6_drain", 200);

    $display("[TB] test 7: PC wrap");
    lat = 1;
    apply_reset();
    bus.id_ready = 1'b0;
    reset = 1'b0;
    tick(12);
    exp_addr_q.push_back(32'hFFFF_FFFF);
    exp_addr_q.push_back(32'd0);
    apply_stimulus(32'hFFFF_FFFF);
    expect_entry(32'hFFFF_FFFF);
    expect_entry(32'd0);
    bus.id_ready = 1'b1;
    wait_drain("t7_drain", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
